chess_time_counter: RTL and testbench

//  Time source for the chess clock: holds both players' remaining mm:ss, counts down the active player once per second, switches turns on button presses and flags timeout.

---
 rtl/chess_pkg.sv | 19 +
 rtl/mmss_down.sv | 55 +++++
 rtl/chess_time_counter.sv | 150 +++++++++++++++
 tb/tb_chess_time_counter.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/chess_pkg.sv
// Shared definitions for the chess clock time source: time width,
// mm:ss limits and the turn-control state encoding.
package chess_pkg;

   localparam int TIME_W  = 6;
   localparam int SEC_MAX = 59;
   localparam int MIN_MAX = 59;

   typedef logic [TIME_W-1:0] time_t;

   typedef enum logic [2:0] {
      IDLE,
      RUN_P1,
      RUN_P2,
      PAUSED,
      TIMEOUT
   } state_t;

endpackage

// File: rtl/mmss_down.sv
// One player's mm:ss down-counter. Decrements by one second per dec pulse,
// borrowing a minute when seconds run out, and saturates at 00:00.
module mmss_down
   import chess_pkg::*;
#(
   parameter int RST_MIN = 5,
   parameter int RST_SEG = 0
) (
   input  logic  clk,
   input  logic  rst_n,
   input  logic  load,
   input  time_t init_min,
   input  time_t init_seg,
   input  logic  dec,
   output time_t min,
   output time_t seg,
   output logic  zero
);

   time_t min_reg, min_next;
   time_t seg_reg, seg_next;

   // Next value: load wins, otherwise borrow-style decrement that never wraps
   always_comb begin
      min_next = min_reg;
      seg_next = seg_reg;
      if (load) begin
         min_next = init_min;
         seg_next = init_seg;
      end else if (dec && !zero) begin
         if (seg_reg != '0) begin
            seg_next = seg_reg - 1'b1;
         end else begin
            min_next = min_reg - 1'b1;
            seg_next = time_t'(SEC_MAX);
         end
      end
   end

   // Time registers, reset straight to the configured starting time
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         min_reg <= time_t'(RST_MIN);
         seg_reg <= time_t'(RST_SEG);
      end else begin
         min_reg <= min_next;
         seg_reg <= seg_next;
      end
   end

   assign min  = min_reg;
   assign seg  = seg_reg;
   assign zero = (min_reg == '0) && (seg_reg == '0);

endmodule

// File: rtl/chess_time_counter.sv
// Chess clock time source: two mm:ss counters, a one-second prescaler that
// runs only while a player is on the clock, and the turn-control FSM.
module chess_time_counter
   import chess_pkg::*;
#(
   parameter int TICK_DIV = 100_000_000,
   parameter int INIT_MIN = 5,
   parameter int INIT_SEG = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              start,
   input  logic              pause,
   input  logic              btn1,
   input  logic              btn2,
   output logic [TIME_W-1:0] min1,
   output logic [TIME_W-1:0] seg1,
   output logic [TIME_W-1:0] min2,
   output logic [TIME_W-1:0] seg2,
   output logic              active,
   output logic              running,
   output logic              timeout1,
   output logic              timeout2
);

   localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
   // Out-of-range start times are clamped so the display never sees >59
   localparam time_t LOAD_MIN = time_t'((INIT_MIN > MIN_MAX) ? MIN_MAX : INIT_MIN);
   localparam time_t LOAD_SEG = time_t'((INIT_SEG > SEC_MAX) ? SEC_MAX : INIT_SEG);

   // Control inputs packed as {load, pause, start, btn2, btn1}
   logic [4:0] ctrl_in, ctrl_prev_reg, ctrl_edge;
   logic       load_e, pause_e, start_e;
   logic [1:0] btn_e_vec;

   state_t               state_reg, state_next;
   logic                 active_reg, active_next;
   logic [1:0]           timeout_reg, timeout_next;
   logic [PRESC_W-1:0]   presc_reg, presc_next;

   logic       running_w, tick, cur;
   logic [1:0] dec_vec, zero_vec, expiring_vec;
   time_t      min_arr [2];
   time_t      seg_arr [2];

   assign ctrl_in   = {load, pause, start, btn2, btn1};
   assign ctrl_edge = ctrl_in & ~ctrl_prev_reg;
   assign load_e    = ctrl_edge[4];
   assign pause_e   = ctrl_edge[3];
   assign start_e   = ctrl_edge[2];
   assign btn_e_vec = ctrl_edge[1:0];

   assign running_w = (state_reg == RUN_P1) || (state_reg == RUN_P2);
   assign tick      = running_w && (presc_reg == PRESC_LAST);
   // Index of the player on the clock: 0 = player 1, 1 = player 2
   assign cur       = (state_reg == RUN_P2);

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_player
         mmss_down #(
            .RST_MIN (int'(LOAD_MIN)),
            .RST_SEG (int'(LOAD_SEG))
         ) u_mmss (
            .clk      (clk),
            .rst_n    (rst_n),
            .load     (load_e),
            .init_min (LOAD_MIN),
            .init_seg (LOAD_SEG),
            .dec      (dec_vec[gi]),
            .min      (min_arr[gi]),
            .seg      (seg_arr[gi]),
            .zero     (zero_vec[gi])
         );
         // The coming decrement lands on 00:00 (or we are already there)
         assign expiring_vec[gi] = zero_vec[gi] ||
                                   ((min_arr[gi] == '0) && (seg_arr[gi] == time_t'(1)));
      end
   endgenerate

   // Turn control, prescaler and decrement requests; load outranks everything
   always_comb begin
      state_next   = state_reg;
      active_next  = active_reg;
      timeout_next = timeout_reg;
      presc_next   = '0;
      dec_vec      = '0;
      if (load_e) begin
         state_next   = IDLE;
         active_next  = 1'b1;
         timeout_next = '0;
      end else begin
         case (state_reg)
            IDLE: begin
               if (start_e) state_next = RUN_P1;
            end
            PAUSED: begin
               if (start_e) state_next = active_reg ? RUN_P1 : RUN_P2;
            end
            RUN_P1, RUN_P2: begin
               // Pause freezes the clock outright, including a coincident tick
               if (pause_e) begin
                  state_next = PAUSED;
               end else begin
                  presc_next   = tick ? '0 : presc_reg + 1'b1;
                  dec_vec[cur] = tick;
                  if (tick && expiring_vec[cur]) begin
                     state_next        = TIMEOUT;
                     timeout_next[cur] = 1'b1;
                  end else if (btn_e_vec[cur]) begin
                     state_next  = (state_reg == RUN_P1) ? RUN_P2 : RUN_P1;
                     active_next = ~active_reg;
                     presc_next  = '0;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // State, flags, prescaler and edge-detect history
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         active_reg    <= 1'b1;
         timeout_reg   <= '0;
         presc_reg     <= '0;
         ctrl_prev_reg <= '0;
      end else begin
         state_reg     <= state_next;
         active_reg    <= active_next;
         timeout_reg   <= timeout_next;
         presc_reg     <= presc_next;
         ctrl_prev_reg <= ctrl_in;
      end
   end

   assign min1     = min_arr[0];
   assign seg1     = seg_arr[0];
   assign min2     = min_arr[1];
   assign seg2     = seg_arr[1];
   assign active   = active_reg;
   assign running  = running_w;
   assign timeout1 = timeout_reg[0];
   assign timeout2 = timeout_reg[1];

endmodule

// File: tb/tb_chess_time_counter.sv
// Bench for chess_time_counter with TICK_DIV=4, INIT 01:02. Inputs change on
// the falling edge; outputs are sampled on the falling edge.
module tb_chess_time_counter;

   logic       clk = 1'b0;
   logic       rst_n, load, start, pause, btn1, btn2;
   logic [5:0] min1, seg1, min2, seg2;
   logic       active, running, timeout1, timeout2;
   logic [27:0] obs;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic [27:0] val;
   } exp_t;

   exp_t sb[$];
   exp_t e;

   always #5 clk = ~clk;

   chess_time_counter #(
      .TICK_DIV (4),
      .INIT_MIN (1),
      .INIT_SEG (2)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load),
      .start    (start),
      .pause    (pause),
      .btn1     (btn1),
      .btn2     (btn2),
      .min1     (min1),
      .seg1     (seg1),
      .min2     (min2),
      .seg2     (seg2),
      .active   (active),
      .running  (running),
      .timeout1 (timeout1),
      .timeout2 (timeout2)
   );

   assign obs = {min1, seg1, min2, seg2, active, running, timeout1, timeout2};

   function automatic logic [27:0] mk(int m1, int s1, int m2, int s2,
                                      bit a, bit r, bit t1, bit t2);
      return {6'(m1), 6'(s1), 6'(m2), 6'(s2), a, r, t1, t2};
   endfunction

   function automatic string fmt(logic [27:0] v);
      return $sformatf("p1=%0d:%0d p2=%0d:%0d active=%0b running=%0b timeout=%0b%0b",
                       v[27:22], v[21:16], v[15:10], v[9:4], v[3], v[2], v[1], v[0]);
   endfunction

   task automatic cycles(int n);
      repeat (n) @(negedge clk);
   endtask

   // One-cycle pulse: 0 load, 1 start, 2 pause, 3 btn1, 4 btn2
   task automatic press(int which);
      case (which)
         0: load  = 1'b1;
         1: start = 1'b1;
         2: pause = 1'b1;
         3: btn1  = 1'b1;
         default: btn2 = 1'b1;
      endcase
      @(negedge clk);
      load = 1'b0; start = 1'b0; pause = 1'b0; btn1 = 1'b0; btn2 = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      sb.push_back('{"reset_state", mk(1, 2, 1, 2, 1, 0, 0, 0)});
      cycles(2);
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s: got %s, want %s", e.name, fmt(obs), fmt(e.val)); end
      else $display("pass %s: %s", e.name, fmt(obs));
      rst_n = 1'b1;
      cycles(1);
   endtask

   task automatic test_countdown();
      press(0);
      sb.push_back('{"countdown_no_tick_yet", mk(1, 2, 1, 2, 1, 1, 0, 0)});
      sb.push_back('{"countdown_2_ticks", mk(1, 0, 1, 2, 1, 1, 0, 0)});
      sb.push_back('{"countdown_borrow", mk(0, 59, 1, 2, 1, 1, 0, 0)});
      press(1);
      cycles(3);
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s: got %s, want %s", e.name, fmt(obs), fmt(e.val)); end
      else $display("pass %s: %s", e.name, fmt(obs));
      cycles(5);
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s: got %s, want %s", e.name, fmt(obs), fmt(e.val)); end
      else $display("pass %s: %s", e.name, fmt(obs));
      cycles(4);
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s: got %s, want %s", e.name, fmt(obs), fmt(e.val)); end
      else $display("pass %s: %s", e.name, fmt(obs));
   endtask

   task automatic test_turns();
      press(0);
      sb.push_back('{"turns_p1_tick", mk(1, 1, 1, 2, 1, 1, 0, 0)});
      sb.push_back('{"turns_btn1_switch", mk(1, 1, 1, 2, 0, 1, 0, 0)});
      sb.push_back('{"turns_p2_tick", mk(1, 1, 1, 1, 0, 1, 0, 0)});
      sb.push_back('{"turns_btn2_switch", mk(1, 1, 1, 1, 1, 1, 0, 0)});
      sb.push_back('{"turns_p1_again", mk(1, 0, 1, 1, 1, 1, 0, 0)});
      press(1);
      cycles(4);
      for (int i = 0; i < 5; i++) begin
         if (i == 1) press(3);
         if (i == 2) cycles(4);
         if (i == 3) press(4);
         if (i == 4) cycles(4);
         e = sb.pop_front(); checks++;
         if (obs !== e.val) begin errors++; $display("FAIL %s: got %s, want %s", e.name, fmt(obs), fmt(e.val)); end
         else $display("pass %s: %s", e.name, fmt(obs));
      end
   endtask

   task automatic test_tick_and_btn();
      press(0);
      sb.push_back('{"tickbtn_dec_then_switch", mk(1, 1, 1, 2, 0, 1, 0, 0)});
      sb.push_back('{"tickbtn_second_btn1_ignored", mk(1, 1, 1, 2, 0, 1, 0, 0)});
      sb.push_back('{"tickbtn_p2_full_second", mk(1, 1, 1, 1, 0, 1, 0, 0)});
      press(1);
      cycles(3);
      press(3);
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s: got %s, want %s", e.name, fmt(obs), fmt(e.val)); end
      else $display("pass %s: %s", e.name, fmt(obs));
      cycles(1);
      press(3);
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s: got %s, want %s", e.name, fmt(obs), fmt(e.val)); end
      else $display("pass %s: %s", e.name, fmt(obs));
      cycles(2);
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s: got %s, want %s", e.name, fmt(obs), fmt(e.val)); end
      else $display("pass %s: %s", e.name, fmt(obs));
   endtask

   task automatic test_pause();
      press(0);
      sb.push_back('{"pause_entered", mk(1, 2, 1, 2, 1, 0, 0, 0)});
      sb.push_back('{"pause_10_ticks_frozen", mk(1, 2, 1, 2, 1, 0, 0, 0)});
      sb.push_back('{"resume_full_second", mk(1, 2, 1, 2, 1, 1, 0, 0)});
      sb.push_back('{"resume_first_tick", mk(1, 1, 1, 2, 1, 1, 0, 0)});
      press(1);
      cycles(2);
      press(2);
      for (int i = 0; i < 4; i++) begin
         if (i == 1) cycles(40);
         if (i == 2) begin press(1); cycles(3); end
         if (i == 3) cycles(1);
         e = sb.pop_front(); checks++;
         if (obs !== e.val) begin errors++; $display("FAIL %s: got %s, want %s", e.name, fmt(obs), fmt(e.val)); end
         else $display("pass %s: %s", e.name, fmt(obs));
      end
   endtask

   task automatic test_timeout();
      press(0);
      sb.push_back('{"timeout_last_second", mk(0, 1, 1, 2, 1, 1, 0, 0)});
      sb.push_back('{"timeout_flag", mk(0, 0, 1, 2, 1, 0, 1, 0)});
      sb.push_back('{"timeout_inputs_ignored", mk(0, 0, 1, 2, 1, 0, 1, 0)});
      sb.push_back('{"timeout_load_restores", mk(1, 2, 1, 2, 1, 0, 0, 0)});
      press(1);
      for (int i = 0; i < 4; i++) begin
         if (i == 0) cycles(4 * 61);
         if (i == 1) cycles(4);
         if (i == 2) begin press(3); cycles(1); press(4); press(1); cycles(8); end
         if (i == 3) press(0);
         e = sb.pop_front(); checks++;
         if (obs !== e.val) begin errors++; $display("FAIL %s: got %s, want %s", e.name, fmt(obs), fmt(e.val)); end
         else $display("pass %s: %s", e.name, fmt(obs));
      end
   endtask

   task automatic test_timeout_beats_switch();
      press(0);
      sb.push_back('{"expire_with_btn1_no_switch", mk(0, 0, 1, 2, 1, 0, 1, 0)});
      sb.push_back('{"expire_then_load", mk(1, 2, 1, 2, 1, 0, 0, 0)});
      press(1);
      cycles(247);
      press(3);
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s: got %s, want %s", e.name, fmt(obs), fmt(e.val)); end
      else $display("pass %s: %s", e.name, fmt(obs));
      press(0);
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s: got %s, want %s", e.name, fmt(obs), fmt(e.val)); end
      else $display("pass %s: %s", e.name, fmt(obs));
   endtask

   task automatic test_async_reset();
      press(0);
      sb.push_back('{"midrun_before_reset", mk(1, 0, 1, 2, 1, 1, 0, 0)});
      sb.push_back('{"midrun_async_reset", mk(1, 2, 1, 2, 1, 0, 0, 0)});
      sb.push_back('{"after_reset_idle", mk(1, 2, 1, 2, 1, 0, 0, 0)});
      press(1);
      cycles(8);
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s: got %s, want %s", e.name, fmt(obs), fmt(e.val)); end
      else $display("pass %s: %s", e.name, fmt(obs));
      rst_n = 1'b0;
      #1;
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s: got %s, want %s", e.name, fmt(obs), fmt(e.val)); end
      else $display("pass %s: %s", e.name, fmt(obs));
      @(negedge clk);
      rst_n = 1'b1;
      cycles(8);
      e = sb.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s: got %s, want %s", e.name, fmt(obs), fmt(e.val)); end
      else $display("pass %s: %s", e.name, fmt(obs));
   endtask

   initial begin
      rst_n = 1'b0;
      load = 1'b0; start = 1'b0; pause = 1'b0; btn1 = 1'b0; btn2 = 1'b0;
      test_reset();
      test_countdown();
      test_turns();
      test_tick_and_btn();
      test_pause();
      test_timeout();
      test_timeout_beats_switch();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: run did not complete, got %0d checks, want completion", checks);
      $fatal(1, "watchdog expired");
   end

endmodule
